// File: rtl/dm_lsu_pkg.sv
// Shared types for the data-memory load/store unit:
// op encodings, FSM states and small op classifiers.
package dm_lsu_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        RESP = 3'd3,
        ERR  = 3'd4
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    function automatic logic is_store(op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_sub(op_e op);
        return (op != OP_LW) && (op != OP_SW);
    endfunction

    function automatic logic [1:0] size(op_e op);
        logic [1:0] s;
        s = SZ_WORD;
        if (op == OP_LB || op == OP_LBU || op == OP_SB) s = SZ_BYTE;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) s = SZ_HALF;
        return s;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte/half lane handling: load extraction with sign/zero
// extension, and lane merge of store data into a read word.
module dm_lane_align
    import dm_lsu_pkg::*;
(
    input  op_e         op,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v     = word[{offset, 3'b000} +: 8];
        half_v     = offset[1] ? word[31:16] : word[15:0];
        load_data  = word;
        merge_data = word;
        unique case (op)
            OP_LB:  load_data = {{24{byte_v[7]}}, byte_v};
            OP_LBU: load_data = {24'd0, byte_v};
            OP_LH:  load_data = {{16{half_v[15]}}, half_v};
            OP_LHU: load_data = {16'd0, half_v};
            OP_SB:  merge_data[{offset, 3'b000} +: 8] = wdata[7:0];
            OP_SH: begin
                if (offset[1]) merge_data[31:16] = wdata[15:0];
                else           merge_data[15:0]  = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_lsu.sv
// Load/store initiator for the word-only data memory;
// sub-word stores go through a read-modify-write sequence.
module dm_lsu
    import dm_lsu_pkg::*;
#(
    parameter int MEM_AW = 10,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              mem_wen,
    input  logic [31:0]       mem_dout
);

    state_e      state;
    state_e      state_nxt;
    op_e         op_q;
    op_e         op_in;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf;
    logic        accept;
    logic        bad;
    logic [31:0] align_word;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign op_in  = op_e'(req_op);
    assign accept = req_valid && req_ready;

    always_comb begin
        bad = |req_addr[ADDR_W-1:MEM_AW+2];
        unique case (size(op_in))
            SZ_HALF: bad = bad || req_addr[0];
            SZ_WORD: bad = bad || (req_addr[1:0] != 2'b00);
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (bad)                                   state_nxt = ERR;
                    else if (is_store(op_in) && !is_sub(op_in)) state_nxt = WR;
                    else                                       state_nxt = RD;
                end
            end
            RD:      state_nxt = is_store(op_q) ? WR : RESP;
            WR:      state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // During RD the merge must see the live memory word; afterwards rbuf holds it.
    assign align_word = (state == RD) ? mem_dout : rbuf;

    dm_lane_align u_align (
        .op         (op_q),
        .offset     (off_q),
        .word       (align_word),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= OP_LB;
            off_q    <= 2'd0;
            wdata_q  <= 32'd0;
            rbuf     <= 32'd0;
            mem_addr <= '0;
            mem_din  <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q    <= op_in;
                off_q   <= req_addr[1:0];
                wdata_q <= req_wdata;
                if (!bad) begin
                    mem_addr <= req_addr[MEM_AW+1:2];
                    if (op_in == OP_SW) mem_din <= req_wdata;
                end
            end
            if (state == RD) begin
                rbuf <= mem_dout;
                if (is_store(op_q)) mem_din <= merge_data;
            end
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP) || (state == ERR);
    assign rsp_err   = (state == ERR);
    assign mem_wen   = (state == WR);
    assign rsp_rdata = (state == RESP && !is_store(op_q)) ? load_data : 32'd0;

endmodule

// File: tb/tb_dm_lsu.sv
// Self-checking bench for dm_lsu: directed vector table,
// reset-abort sequence and randomized ops against a byte model.
module tb_dm_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic        mem_wen;
    logic [31:0] mem_dout;

    logic [31:0] mem [1024];
    logic [7:0]  ref_b [4096];

    int n_cmp = 0;
    int n_bad = 0;
    int wen_cnt = 0;
    int acc_cnt = 0;
    int exp_acc = 0;
    int ready_viol = 0;

    always #5 clk = ~clk;

    dm_lsu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_wen   (mem_wen),
        .mem_dout  (mem_dout)
    );

    assign mem_dout = mem[mem_addr];

    always @(negedge clk) begin
        if (mem_wen) begin
            mem[mem_addr] = mem_din;
            wen_cnt++;
        end
    end

    always @(posedge clk) begin
        if (rst_n && req_valid && req_ready) acc_cnt++;
    end

    always @(posedge clk) begin
        #1;
        if (req_ready && (mem_wen || rsp_valid)) ready_viol++;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic poke(input int w, input logic [31:0] v);
        mem[w] = v;
        for (int k = 0; k < 4; k++) ref_b[4*w+k] = v[8*k +: 8];
    endtask

    function automatic logic [31:0] ref_word(input int a);
        return {ref_b[a+3], ref_b[a+2], ref_b[a+1], ref_b[a]};
    endfunction

    // Reference behaviour from the op rules over a byte-addressed memory.
    task automatic model(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] wd, output bit e,
                         output logic [31:0] rd, output int lat,
                         output int nw);
        int sz;
        sz = (op == 0 || op == 1 || op == 5) ? 1 :
             (op == 2 || op == 3 || op == 6) ? 2 : 4;
        e  = (a >= 32'd4096) || (a % sz != 0);
        rd = 32'd0;
        nw = 0;
        if (e) lat = 1;
        else if (op == 5 || op == 6) lat = 3;
        else lat = 2;
        if (!e) begin
            case (op)
                3'd0: rd = 32'($signed(ref_b[a]));
                3'd1: rd = 32'(ref_b[a]);
                3'd2: rd = 32'($signed({ref_b[a+1], ref_b[a]}));
                3'd3: rd = 32'({ref_b[a+1], ref_b[a]});
                3'd4: rd = ref_word(int'(a));
                3'd5: begin ref_b[a] = wd[7:0]; nw = 1; end
                3'd6: begin
                    ref_b[a]   = wd[7:0];
                    ref_b[a+1] = wd[15:8];
                    nw = 1;
                end
                default: begin
                    for (int k = 0; k < 4; k++) ref_b[a+k] = wd[8*k +: 8];
                    nw = 1;
                end
            endcase
        end
    endtask

    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    // Leaves req_valid high so consecutive calls run back to back.
    task automatic do_req(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] wd, output bit e,
                          output logic [31:0] rd, output int lat);
        bit ok;
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
        req_valid = 1'b1;
        exp_acc++;
        wait_accept(ok);
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        lat = 0;
        e   = 1'b0;
        rd  = 32'd0;
        for (int i = 1; i <= 8; i++) begin
            if (rsp_valid) begin
                lat = i;
                e   = rsp_err;
                rd  = rsp_rdata;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] rdata;
        int          lat;
        int          nwen;
    } vec_t;

    vec_t vecs [14];

    initial begin
        bit          e;
        logic [31:0] rd;
        int          lat;
        bit          me;
        logic [31:0] mrd;
        int          mlat;
        int          mnw;
        bit          ok;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] wd;

        vecs[0]  = '{3'd7, 32'h10,   32'hDEADBEEF, 0, 32'h0,        2, 1};
        vecs[1]  = '{3'd4, 32'h10,   32'h0,        0, 32'hDEADBEEF, 2, 0};
        vecs[2]  = '{3'd5, 32'h22,   32'h000000AA, 0, 32'h0,        3, 1};
        vecs[3]  = '{3'd4, 32'h20,   32'h0,        0, 32'h11AA3344, 2, 0};
        vecs[4]  = '{3'd0, 32'h31,   32'h0,        0, 32'h0000007F, 2, 0};
        vecs[5]  = '{3'd0, 32'h32,   32'h0,        0, 32'hFFFFFFFF, 2, 0};
        vecs[6]  = '{3'd1, 32'h33,   32'h0,        0, 32'h00000080, 2, 0};
        vecs[7]  = '{3'd2, 32'h32,   32'h0,        0, 32'hFFFF80FF, 2, 0};
        vecs[8]  = '{3'd3, 32'h30,   32'h0,        0, 32'h00007F01, 2, 0};
        vecs[9]  = '{3'd6, 32'h41,   32'h12345678, 1, 32'h0,        1, 0};
        vecs[10] = '{3'd4, 32'h42,   32'h0,        1, 32'h0,        1, 0};
        vecs[11] = '{3'd7, 32'h1000, 32'hCAFEF00D, 1, 32'h0,        1, 0};
        vecs[12] = '{3'd6, 32'h42,   32'h1234BEEF, 0, 32'h0,        3, 1};
        vecs[13] = '{3'd4, 32'h40,   32'h0,        0, 32'hBEEF0000, 2, 0};

        for (int w = 0; w < 1024; w++) poke(w, 32'd0);
        poke(8, 32'h11223344);
        poke(12, 32'h80FF7F01);

        #12;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err",   32'(rsp_err),   32'd0);
        check("rst_rsp_rdata", rsp_rdata,      32'd0);
        check("rst_mem_wen",   32'(mem_wen),   32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_mem_din",   mem_din,        32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            wen_cnt = 0;
            do_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, e, rd, lat);
            model(vecs[i].op, vecs[i].addr, vecs[i].wdata, me, mrd, mlat, mnw);
            check($sformatf("v%0d_err", i),   32'(e),       32'(vecs[i].err));
            check($sformatf("v%0d_rdata", i), rd,           vecs[i].rdata);
            check($sformatf("v%0d_lat", i),   32'(lat),     32'(vecs[i].lat));
            check($sformatf("v%0d_wen", i),   32'(wen_cnt), 32'(vecs[i].nwen));
        end
        check("word0_untouched", mem[0], 32'd0);

        // Reset lands in the WR cycle of an SB, before its negedge write.
        poke(20, 32'h11223344);
        req_op    = 3'd5;
        req_addr  = 32'h51;
        req_wdata = 32'h00000055;
        req_valid = 1'b1;
        exp_acc++;
        wait_accept(ok);
        if (!ok) check("abort_accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
        wen_cnt   = 0;
        @(posedge clk); #1;
        check("abort_in_wr", 32'(mem_wen), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_wen_drop", 32'(mem_wen), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        check("abort_no_rsp",  32'(rsp_valid), 32'd0);
        check("abort_no_wen",  32'(wen_cnt),   32'd0);
        check("abort_word",    mem[20],        32'h11223344);

        for (int w = 0; w < 64; w++) poke(w, $urandom);
        for (int n = 0; n < 400; n++) begin
            op = 3'($urandom_range(0, 7));
            wd = $urandom;
            if ($urandom_range(0, 9) == 0)
                a = (32'h1000 << $urandom_range(0, 19)) | 32'($urandom_range(0, 4095));
            else
                a = 32'($urandom_range(0, 255));
            wen_cnt = 0;
            model(op, a, wd, me, mrd, mlat, mnw);
            do_req(op, a, wd, e, rd, lat);
            check($sformatf("r%0d_err", n),   32'(e),       32'(me));
            check($sformatf("r%0d_rdata", n), rd,           mrd);
            check($sformatf("r%0d_lat", n),   32'(lat),     32'(mlat));
            check($sformatf("r%0d_wen", n),   32'(wen_cnt), 32'(mnw));
            if (a < 32'd4096)
                check($sformatf("r%0d_word", n), mem[a[11:2]],
                      ref_word(int'({a[31:2], 2'b00})));
        end
        req_valid = 1'b0;
        @(posedge clk); #1;

        check("accept_count", 32'(acc_cnt),    32'(exp_acc));
        check("ready_busy",   32'(ready_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
